// File: rtl/jtgng_irqctl.sv
// Multi-channel vectored interrupt controller for a Z80 in IM0: latches requests,
// masks and prioritises them, drives INT_n and supplies an RST vector on acknowledge.
module jtgng_irqctl #(
  parameter int              CH       = 4,
  parameter logic [CH-1:0]   EDGE     = {CH{1'b1}},
  parameter logic [CH-1:0]   MASK_RST = {CH{1'b1}},
  parameter logic [7:0]      VBASE    = 8'hC7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen_i,
  input  logic [CH-1:0] trig_i,
  input  logic          mask_we_i,
  input  logic [CH-1:0] mask_din_i,
  input  logic          clr_we_i,
  input  logic [CH-1:0] clr_din_i,
  input  logic          iorq_n_i,
  input  logic          m1_n_i,
  output logic          int_n_o,
  output logic [7:0]    vector_o,
  output logic [CH-1:0] pending_o,
  output logic [CH-1:0] mask_o,
  output logic [2:0]    active_ch_o
);

  logic [CH-1:0] trigPrev_q;
  logic          ackPrev_q;
  logic [CH-1:0] pending_q, pending_d;
  logic [CH-1:0] mask_q, mask_d;
  logic          int_n_q, int_n_d;
  logic [7:0]    vector_q, vector_d;
  logic [2:0]    active_ch_q, active_ch_d;

  logic          ack, ackStart, anyEn;
  logic [CH-1:0] req, enabled, selHot, clr;
  logic [2:0]    sel;

  assign ack      = ~iorq_n_i & ~m1_n_i;
  assign ackStart = ack & ~ackPrev_q;
  assign req      = (trig_i & ~trigPrev_q & EDGE) | (trig_i & ~EDGE);
  assign enabled  = pending_q & mask_q;

  // Lowest-index enabled channel wins; scanning downwards lets the last hit be the lowest.
  always_comb begin
    sel   = 3'd0;
    anyEn = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (enabled[i]) begin
        sel   = 3'(i);
        anyEn = 1'b1;
      end
    end
    selHot = '0;
    for (int i = 0; i < CH; i++) begin
      selHot[i] = (sel == 3'(i));
    end
  end

  always_comb begin
    clr = clr_we_i ? clr_din_i : '0;
    if (ackStart && anyEn) begin
      clr = clr | selHot;
    end
    // New requests are OR-ed in after clearing so a coincident event is never lost.
    pending_d   = req | (pending_q & ~clr);
    mask_d      = mask_we_i ? mask_din_i : mask_q;
    int_n_d     = ~|(pending_d & mask_d);
    vector_d    = vector_q;
    active_ch_d = active_ch_q;
    if (ackStart) begin
      if (anyEn) begin
        vector_d    = VBASE | {2'b00, sel, 3'b000};
        active_ch_d = sel;
      end else begin
        vector_d    = 8'hFF;
      end
    end
  end

  // Reset leaves ackPrev at 0, so an ack still held across reset looks spurious on the
  // first cen; with nothing pending that is harmless and later acks need a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      trigPrev_q  <= '0;
      ackPrev_q   <= 1'b0;
      pending_q   <= '0;
      mask_q      <= MASK_RST;
      int_n_q     <= 1'b1;
      vector_q    <= 8'hFF;
      active_ch_q <= 3'd0;
    end else if (cen_i) begin
      trigPrev_q  <= trig_i;
      ackPrev_q   <= ack;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      int_n_q     <= int_n_d;
      vector_q    <= vector_d;
      active_ch_q <= active_ch_d;
    end
  end

  assign int_n_o     = int_n_q;
  assign vector_o    = vector_q;
  assign pending_o   = pending_q;
  assign mask_o      = mask_q;
  assign active_ch_o = active_ch_q;

endmodule

// File: tb/tb_jtgng_irqctl.sv
// Table-driven bench for jtgng_irqctl (CH=4, all edge-triggered) with an
// expected-value queue filled on drive and drained after each clock.
module tb_jtgng_irqctl;

  typedef struct {
    logic       rst;
    logic       cen;
    logic [3:0] trig;
    logic       maskWe;
    logic [3:0] maskDin;
    logic       clrWe;
    logic [3:0] clrDin;
    logic       ack;
    logic       expIntN;
    logic [3:0] expPending;
    logic [3:0] expMask;
    logic [7:0] expVector;
    logic [2:0] expActive;
  } stepT;

  logic       clk = 1'b0;
  logic       rst, cen, maskWe, clrWe, iorqN, m1N;
  logic [3:0] trig, maskDin, clrDin;
  logic       intN;
  logic [7:0] vector;
  logic [3:0] pending, mask;
  logic [2:0] activeCh;

  int   compared = 0;
  int   mismatched = 0;
  stepT expQ[$];
  stepT tbl[35];

  jtgng_irqctl #(.CH(4), .EDGE(4'hF), .MASK_RST(4'hF), .VBASE(8'hC7)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen_i      (cen),
    .trig_i     (trig),
    .mask_we_i  (maskWe),
    .mask_din_i (maskDin),
    .clr_we_i   (clrWe),
    .clr_din_i  (clrDin),
    .iorq_n_i   (iorqN),
    .m1_n_i     (m1N),
    .int_n_o    (intN),
    .vector_o   (vector),
    .pending_o  (pending),
    .mask_o     (mask),
    .active_ch_o(activeCh)
  );

  always #5 clk = ~clk;

  function automatic stepT mk(logic r, logic c, logic [3:0] t, logic mw, logic [3:0] md,
                              logic cw, logic [3:0] cd, logic a, logic ei, logic [3:0] ep,
                              logic [3:0] em, logic [7:0] ev, logic [2:0] ea);
    stepT s;
    s.rst = r; s.cen = c; s.trig = t; s.maskWe = mw; s.maskDin = md;
    s.clrWe = cw; s.clrDin = cd; s.ack = a;
    s.expIntN = ei; s.expPending = ep; s.expMask = em; s.expVector = ev; s.expActive = ea;
    return s;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input stepT s);
    @(negedge clk);
    rst = s.rst; cen = s.cen; trig = s.trig;
    maskWe = s.maskWe; maskDin = s.maskDin;
    clrWe = s.clrWe; clrDin = s.clrDin;
    iorqN = ~s.ack; m1N = ~s.ack;
    expQ.push_back(s);
  endtask

  task automatic checkOutput(input int idx);
    stepT e;
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard step %0d: got empty queue, expected an entry", idx);
    end else begin
      e = expQ.pop_front();
      chk("int_n",     idx, {7'd0, intN},     {7'd0, e.expIntN});
      chk("pending",   idx, {4'd0, pending},  {4'd0, e.expPending});
      chk("mask",      idx, {4'd0, mask},     {4'd0, e.expMask});
      chk("vector",    idx, vector,           e.expVector);
      chk("active_ch", idx, {5'd0, activeCh}, {5'd0, e.expActive});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    rst = 1'b1; cen = 1'b1; trig = '0; maskWe = 1'b0; maskDin = '0;
    clrWe = 1'b0; clrDin = '0; iorqN = 1'b1; m1N = 1'b1;

    //          rst cen trig mwe mdin cwe cdin ack | intN pend mask vec    act
    tbl[0]  = mk(1, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0,   1, 4'h0, 4'hF, 8'hFF, 3'd0);
    tbl[1]  = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0,   1, 4'h0, 4'hF, 8'hFF, 3'd0);
    tbl[2]  = mk(0, 1, 4'h4, 0, 4'h0, 0, 4'h0, 0,   0, 4'h4, 4'hF, 8'hFF, 3'd0);
    tbl[3]  = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0,   0, 4'h4, 4'hF, 8'hFF, 3'd0);
    tbl[4]  = mk(0, 0, 4'h4, 0, 4'h0, 0, 4'h0, 0,   0, 4'h4, 4'hF, 8'hFF, 3'd0);
    tbl[5]  = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 1,   1, 4'h0, 4'hF, 8'hD7, 3'd2);
    tbl[6]  = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 1,   1, 4'h0, 4'hF, 8'hD7, 3'd2);
    tbl[7]  = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0,   1, 4'h0, 4'hF, 8'hD7, 3'd2);
    tbl[8]  = mk(0, 1, 4'hA, 0, 4'h0, 0, 4'h0, 0,   0, 4'hA, 4'hF, 8'hD7, 3'd2);
    tbl[9]  = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 1,   0, 4'h8, 4'hF, 8'hCF, 3'd1);
    tbl[10] = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0,   0, 4'h8, 4'hF, 8'hCF, 3'd1);
    tbl[11] = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 1,   1, 4'h0, 4'hF, 8'hDF, 3'd3);
    tbl[12] = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0,   1, 4'h0, 4'hF, 8'hDF, 3'd3);
    tbl[13] = mk(0, 1, 4'h0, 1, 4'hE, 0, 4'h0, 0,   1, 4'h0, 4'hE, 8'hDF, 3'd3);
    tbl[14] = mk(0, 1, 4'h1, 0, 4'h0, 0, 4'h0, 0,   1, 4'h1, 4'hE, 8'hDF, 3'd3);
    tbl[15] = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0,   1, 4'h1, 4'hE, 8'hDF, 3'd3);
    tbl[16] = mk(0, 1, 4'h0, 1, 4'hF, 0, 4'h0, 0,   0, 4'h1, 4'hF, 8'hDF, 3'd3);
    tbl[17] = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 1,   1, 4'h0, 4'hF, 8'hC7, 3'd0);
    tbl[18] = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0,   1, 4'h0, 4'hF, 8'hC7, 3'd0);
    tbl[19] = mk(0, 1, 4'h4, 0, 4'h0, 0, 4'h0, 0,   0, 4'h4, 4'hF, 8'hC7, 3'd0);
    tbl[20] = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0,   0, 4'h4, 4'hF, 8'hC7, 3'd0);
    tbl[21] = mk(0, 1, 4'h4, 0, 4'h0, 0, 4'h0, 1,   0, 4'h4, 4'hF, 8'hD7, 3'd2);
    tbl[22] = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0,   0, 4'h4, 4'hF, 8'hD7, 3'd2);
    tbl[23] = mk(0, 1, 4'h0, 0, 4'h0, 1, 4'h4, 0,   1, 4'h0, 4'hF, 8'hD7, 3'd2);
    tbl[24] = mk(0, 1, 4'h4, 0, 4'h0, 1, 4'h4, 0,   0, 4'h4, 4'hF, 8'hD7, 3'd2);
    tbl[25] = mk(0, 1, 4'h0, 0, 4'h0, 1, 4'h4, 0,   1, 4'h0, 4'hF, 8'hD7, 3'd2);
    tbl[26] = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 1,   1, 4'h0, 4'hF, 8'hFF, 3'd2);
    tbl[27] = mk(0, 1, 4'h1, 1, 4'hE, 0, 4'h0, 1,   1, 4'h1, 4'hE, 8'hFF, 3'd2);
    tbl[28] = mk(1, 1, 4'h0, 0, 4'h0, 0, 4'h0, 1,   1, 4'h0, 4'hF, 8'hFF, 3'd0);
    tbl[29] = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 1,   1, 4'h0, 4'hF, 8'hFF, 3'd0);
    tbl[30] = mk(0, 1, 4'h8, 0, 4'h0, 0, 4'h0, 1,   0, 4'h8, 4'hF, 8'hFF, 3'd0);
    tbl[31] = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 1,   0, 4'h8, 4'hF, 8'hFF, 3'd0);
    tbl[32] = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0,   0, 4'h8, 4'hF, 8'hFF, 3'd0);
    tbl[33] = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 1,   1, 4'h0, 4'hF, 8'hDF, 3'd3);
    tbl[34] = mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0,   1, 4'h0, 4'hF, 8'hDF, 3'd3);

    for (int i = 0; i < 35; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(i);
    end

    // An edge on trig[1] must pull int_n low after exactly one enabled clock.
    @(negedge clk);
    trig = 4'h2;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (intN == 1'b0) break;
    end
    chk("int_n_latency", 100, lat[7:0], 8'd1);

    // An ack seen while cen is low must not take effect until cen returns.
    applyStimulus(mk(0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 1,   0, 4'h2, 4'hF, 8'hDF, 3'd3));
    checkOutput(101);
    applyStimulus(mk(0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 1,   0, 4'h2, 4'hF, 8'hDF, 3'd3));
    checkOutput(102);
    applyStimulus(mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 1,   1, 4'h0, 4'hF, 8'hCF, 3'd1));
    checkOutput(103);
    applyStimulus(mk(0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0,   1, 4'h0, 4'hF, 8'hCF, 3'd1));
    checkOutput(104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
